// File: rtl/freq_display_scan.sv
// freq_display_scan: captures four BCD digits on a latch strobe and scans
// them onto a 4-digit common-anode display. Option: FREQ_DISPLAY_LZB_EN.
module freq_display_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        latch,
    input  logic [15:0] bcd_in,
    input  logic        ovf_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] RC_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] RC_ONE = RW'(1);

    logic [RW-1:0] rc;
    logic [RW-1:0] rc_next;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [15:0]   shadow;
    logic          ovf_sh;
    logic          run;
    logic [3:0]    digit;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          dp_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

`ifdef FREQ_DISPLAY_LZB_EN
    logic [1:0] msd;

    // index of the most significant nonzero digit (0 when all are zero)
    always_comb begin
        msd = 2'd0;
        if (shadow[15:12] != 4'd0)
            msd = 2'd3;
        else if (shadow[11:8] != 4'd0)
            msd = 2'd2;
        else if (shadow[7:4] != 4'd0)
            msd = 2'd1;
    end
`endif

    // next scan position; the first edge out of reset replays slot 0's dead cycle
    always_comb begin
        rc_next  = rc;
        idx_next = idx;
        if (!run) begin
            rc_next  = '0;
            idx_next = 2'd0;
        end else if (rc == RC_MAX) begin
            rc_next  = '0;
            idx_next = idx + 2'd1;
        end else begin
            rc_next = rc + RC_ONE;
        end
    end

    // pick the shadow digit for the slot being entered
    always_comb begin
        case (idx_next)
            2'd0:    digit = shadow[3:0];
            2'd1:    digit = shadow[7:4];
            2'd2:    digit = shadow[11:8];
            default: digit = shadow[15:12];
        endcase
    end

    // output values for the upcoming (rc, idx) state
    always_comb begin
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (rc_next != '0) begin
            an_next  = ~(4'b0001 << idx_next);
            seg_next = decode(digit);
            dp_next  = ~ovf_sh;
`ifdef FREQ_DISPLAY_LZB_EN
            if (idx_next > msd)
                seg_next = 7'b1111111;
`endif
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rc     <= '0;
            idx    <= 2'd0;
            run    <= 1'b0;
            shadow <= 16'h0000;
            ovf_sh <= 1'b0;
            an     <= 4'b1111;
            seg    <= 7'b1111111;
            dp     <= 1'b1;
        end else begin
            rc  <= rc_next;
            idx <= idx_next;
            run <= 1'b1;
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
            if (latch) begin
                shadow <= bcd_in;
                ovf_sh <= ovf_in;
            end
        end
    end

endmodule

// File: tb/tb_freq_display_scan.sv
// tb_freq_display_scan: directed vector bench for freq_display_scan
// with REFRESH_DIV=4.
module tb_freq_display_scan;

    typedef struct {
        logic        rst;
        logic        lat;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

`ifdef FREQ_DISPLAY_LZB_EN
    localparam logic [6:0] ZB = 7'h7f;
`else
    localparam logic [6:0] ZB = 7'h40;
`endif
    localparam logic [6:0] BL = 7'h7f;

    logic        clk = 1'b0;
    logic        reset;
    logic        latch;
    logic [15:0] bcd_in;
    logic        ovf_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    freq_display_scan #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .latch  (latch),
        .bcd_in (bcd_in),
        .ovf_in (ovf_in),
        .seg    (seg),
        .an     (an),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic l, logic [15:0] b, logic o,
                                logic [3:0] a, logic [6:0] s, logic d);
        vec_t v;
        v.rst = r; v.lat = l; v.bcd = b; v.ovf = o;
        v.an = a; v.seg = s; v.dp = d;
        return v;
    endfunction

    function automatic logic [3:0] an_of(int i);
        logic [3:0] a;
        a = 4'b0001 << i;
        return ~a;
    endfunction

    // one slot: dead cycle (carrying any latch) then three active cycles
    function automatic void slot(int i, logic [6:0] s, logic d,
                                 logic l, logic [15:0] b, logic o);
        tbl.push_back(mk(1'b0, l, b, o, 4'b1111, BL, 1'b1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1'b0, 1'b0, 16'h0, 1'b0, an_of(i), s, d));
    endfunction

    task automatic apply(input vec_t v, input string tag);
        reset  = v.rst;
        latch  = v.lat;
        bcd_in = v.bcd;
        ovf_in = v.ovf;
        @(posedge clk);
        #1;
        checks++;
        if ({an, seg, dp} !== {v.an, v.seg, v.dp}) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     tag, an, seg, dp, v.an, v.seg, v.dp);
        end
    endtask

    initial begin
        reset = 1'b1; latch = 1'b0; bcd_in = 16'h0; ovf_in = 1'b0;

        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1'b1, 1'b1, 16'h9999, 1'b0, 4'b1111, BL, 1'b1));
        slot(0, 7'h40, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(1, ZB, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(2, ZB, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(3, ZB, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(0, 7'h19, 1'b1, 1'b1, 16'h1234, 1'b0);
        slot(1, 7'h30, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(2, 7'h24, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(3, 7'h79, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(0, 7'h19, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(1, 7'h30, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(2, 7'h24, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(3, 7'h79, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(0, 7'h24, 1'b1, 1'b1, 16'h0042, 1'b0);
        slot(1, 7'h19, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(2, ZB, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(3, ZB, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(0, 7'h12, 1'b0, 1'b1, 16'h00A5, 1'b1);
        slot(1, 7'h3f, 1'b0, 1'b0, 16'h0, 1'b0);
        slot(2, ZB, 1'b0, 1'b0, 16'h0, 1'b0);
        slot(3, ZB, 1'b0, 1'b0, 16'h0, 1'b0);
        slot(0, 7'h00, 1'b1, 1'b1, 16'h0008, 1'b0);
        slot(1, ZB, 1'b1, 1'b1, 16'h0007, 1'b0);
        slot(2, ZB, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(3, ZB, 1'b1, 1'b0, 16'h0, 1'b0);
        slot(0, 7'h78, 1'b1, 1'b0, 16'h0, 1'b0);

        foreach (tbl[i])
            apply(tbl[i], $sformatf("vec%0d", i));

        // latch mid-slot: visible from the following edge
        apply(mk(0, 0, 16'h0, 0, 4'b1111, BL, 1), "lat_dead");
        apply(mk(0, 1, 16'h0093, 0, 4'b1101, ZB, 1), "lat_edge");
        apply(mk(0, 0, 16'h0, 0, 4'b1101, 7'h10, 1), "lat_next");
        apply(mk(0, 0, 16'h0, 0, 4'b1101, 7'h10, 1), "lat_hold");

        // reset during digit 2's active phase
        apply(mk(0, 0, 16'h0, 0, 4'b1111, BL, 1), "d2_dead");
        apply(mk(0, 0, 16'h0, 0, 4'b1011, ZB, 1), "d2_act");
        apply(mk(1, 0, 16'h0, 0, 4'b1111, BL, 1), "rst_mid");
        apply(mk(1, 1, 16'h5555, 1, 4'b1111, BL, 1), "rst_lat");
        apply(mk(0, 0, 16'h0, 0, 4'b1111, BL, 1), "rel_dead");
        for (int k = 0; k < 3; k++)
            apply(mk(0, 0, 16'h0, 0, 4'b1110, 7'h40, 1), "rel_d0");
        apply(mk(0, 0, 16'h0, 0, 4'b1111, BL, 1), "rel_d1dead");
        apply(mk(0, 0, 16'h0, 0, 4'b1101, ZB, 1), "rel_d1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
